// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between an initiator and mem_responder.
// The initiator drives master; the responder takes slave.
interface mem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_write;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_write
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_write
  );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one request, waits a fixed
// latency, performs the access, then holds the response until accepted.
module mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              report,
  mem_responder_if.slave    bus,
  output logic [15:0]       read_count,
  output logic [15:0]       write_count
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            lat_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rwrite_q;
  logic [15:0]           rd_cnt_q;
  logic [15:0]           wr_cnt_q;
  logic                  accept;
  logic                  access;
  logic                  req_ready_c;
  logic                  resp_valid_c;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // The stats strobe only triggers a simulation-side printout; the datapath ignores it.
  logic unused_report;
  assign unused_report = report;

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    access       = 1'b0;
    req_ready_c  = 1'b0;
    resp_valid_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid_c = 1'b1;
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rwrite_q <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (accept) begin
        wr_q    <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        lat_q   <= 4'(LATENCY - 1);
        if (bus.req_write) begin
          if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
        end else begin
          if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
        end
      end else if (state_q == WAIT && lat_q != '0) begin
        lat_q <= lat_q - 4'd1;
      end
      if (access) begin
        rwrite_q <= wr_q;
        rdata_q  <= wr_q ? '0 : mem[addr_q];
      end
    end
  end

  // Storage has no reset; an aborted request never reaches the access edge.
  always_ff @(posedge clk) begin
    if (access && wr_q) mem[addr_q] <= wdata_q;
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_c;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_write = rwrite_q;
  assign read_count     = rd_cnt_q;
  assign write_count    = wr_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY 4 main instance,
// plus a LATENCY 1 instance for the minimum-latency case).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        report;
  logic [15:0] read_count, write_count;
  logic [15:0] rc1, wc1;
  int          checks = 0;
  int          failures = 0;
  int          lat;

  always #5 clk = ~clk;

  mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();
  mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus1 ();

  mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LATENCY(4)) dut (
    .clk(clk), .rst(rst), .report(report), .bus(bus),
    .read_count(read_count), .write_count(write_count)
  );

  mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .report(1'b0), .bus(bus1),
    .read_count(rc1), .write_count(wc1)
  );

  always @(posedge clk)
    if (report)
      $display("stats: read_count=%0d write_count=%0d DATA_WIDTH=32 ADDR_WIDTH=8 LATENCY=4",
               read_count, write_count);

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request on the LATENCY-4 instance; return edges until resp_valid.
  task automatic do_req(input logic w, input logic [7:0] a, input logic [31:0] d,
                        input bit scramble, output int n);
    @(negedge clk);
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      if (scramble) begin
        bus.req_write = ~w;
        bus.req_addr  = a ^ 8'(8'h5A + n);
        bus.req_wdata = 32'h1111_0000 + 32'(n);
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic finish_resp(input string tag);
    chk({tag, "_req_ready_resp"}, bus.req_ready, 0);
    @(posedge clk); #1;
    chk({tag, "_resp_valid_done"}, bus.resp_valid, 0);
    chk({tag, "_req_ready_done"}, bus.req_ready, 1);
  endtask

  initial begin
    rst = 1'b1; report = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.resp_ready = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    bus1.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_resp_write", bus.resp_write, 0);
    chk("rst_read_count", read_count, 0);
    chk("rst_write_count", write_count, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    @(negedge clk); rst = 1'b0;

    // Write then read the same word
    do_req(1'b1, 8'h10, 32'hDEADBEEF, 1'b0, lat);
    chk("wr_latency", lat, 4);
    chk("wr_resp_write", bus.resp_write, 1);
    chk("wr_resp_rdata", bus.resp_rdata, 0);
    chk("wr_write_count", write_count, 1);
    finish_resp("wr");
    do_req(1'b0, 8'h10, 32'h0, 1'b0, lat);
    chk("rd_latency", lat, 4);
    chk("rd_resp_rdata", bus.resp_rdata, 32'hDEADBEEF);
    chk("rd_resp_write", bus.resp_write, 0);
    chk("rd_read_count", read_count, 1);
    finish_resp("rd");

    // Backpressure: response held for 6 cycles
    @(negedge clk); bus.resp_ready = 1'b0;
    do_req(1'b0, 8'h10, 32'h0, 1'b0, lat);
    chk("bp_latency", lat, 4);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("bp_resp_valid", bus.resp_valid, 1);
      chk("bp_resp_rdata", bus.resp_rdata, 32'hDEADBEEF);
      chk("bp_req_ready", bus.req_ready, 0);
    end
    @(negedge clk); bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", bus.resp_valid, 0);
    chk("bp_release_ready", bus.req_ready, 1);
    chk("bp_rdata_hold", bus.resp_rdata, 32'hDEADBEEF);
    chk("bp_read_count", read_count, 2);

    // Inputs scrambled during WAIT must not matter
    do_req(1'b1, 8'h20, 32'hA5A5A5A5, 1'b1, lat);
    chk("scr_wr_latency", lat, 4);
    chk("scr_wr_resp_write", bus.resp_write, 1);
    finish_resp("scr_wr");
    do_req(1'b0, 8'h20, 32'h0, 1'b1, lat);
    chk("scr_rd_rdata", bus.resp_rdata, 32'hA5A5A5A5);
    chk("scr_rd_resp_write", bus.resp_write, 0);
    finish_resp("scr_rd");
    do_req(1'b0, 8'h10, 32'h0, 1'b0, lat);
    chk("scr_rd10_rdata", bus.resp_rdata, 32'hDEADBEEF);
    finish_resp("scr_rd10");
    chk("scr_write_count", write_count, 2);
    chk("scr_read_count", read_count, 4);

    // Stats strobe has no effect on state
    @(negedge clk); report = 1'b1;
    @(negedge clk); report = 1'b0;
    chk("report_read_count", read_count, 4);
    chk("report_req_ready", bus.req_ready, 1);

    // Reset two cycles into WAIT aborts the write
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 8'h20; bus.req_wdata = 32'h1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1; #1;
    chk("abort_resp_valid", bus.resp_valid, 0);
    chk("abort_read_count", read_count, 0);
    chk("abort_write_count", write_count, 0);
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_resp", bus.resp_valid, 0);
    end
    do_req(1'b0, 8'h20, 32'h0, 1'b0, lat);
    chk("abort_rd_rdata", bus.resp_rdata, 32'hA5A5A5A5);
    chk("abort_rd_count", read_count, 1);
    finish_resp("abort_rd");

    // Reset while a response is presented drops it at once
    @(negedge clk); bus.resp_ready = 1'b0;
    do_req(1'b0, 8'h10, 32'h0, 1'b0, lat);
    chk("rresp_valid_before", bus.resp_valid, 1);
    #2 rst = 1'b1; #1;
    chk("rresp_valid_after", bus.resp_valid, 0);
    chk("rresp_rdata_after", bus.resp_rdata, 0);
    @(negedge clk); rst = 1'b0; bus.resp_ready = 1'b1;

    // Read counter saturation
    @(negedge clk);
    force dut.rd_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.rd_cnt_q;
    chk("sat_preset", read_count, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, 8'h10, 32'h0, 1'b0, lat);
      chk("sat_rdata", bus.resp_rdata, 32'hDEADBEEF);
      finish_resp("sat");
      chk("sat_read_count", read_count, 16'hFFFF);
    end
    chk("sat_write_count", write_count, 0);

    // Minimum latency instance
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_write = 1'b1; bus1.req_addr = 8'h03; bus1.req_wdata = 32'h12345678;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    chk("l1_wr_wait", bus1.resp_valid, 0);
    @(posedge clk); #1;
    chk("l1_wr_valid", bus1.resp_valid, 1);
    chk("l1_wr_write", bus1.resp_write, 1);
    @(posedge clk); #1;
    chk("l1_wr_done", bus1.resp_valid, 0);
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_write = 1'b0; bus1.req_addr = 8'h03;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    chk("l1_rd_wait", bus1.resp_valid, 0);
    @(posedge clk); #1;
    chk("l1_rd_valid", bus1.resp_valid, 1);
    chk("l1_rd_rdata", bus1.resp_rdata, 32'h12345678);
    chk("l1_counts", {rc1, wc1}, {16'd1, 16'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
